eth_radio_stream_router: RTL and testbench
==========================================

Name: eth_radio_stream_router

Overview:
- Multi-channel successor to the single-radio Ethernet stream controller.
- Ingress: parses the CHDR header of each Ethernet-to-Vita packet and routes it to one of three places:
  - the shared control output;
  - one of NUM_CH radio TX data outputs, chosen by destination EPID;
  - a drop sink, for malformed or unmapped packets.
- Egress: packet-granular round-robin arbitration of the radio response stream plus NUM_CH RX streams onto the single Vita-to-Ethernet output.
- Sits between the Ethernet adapter and the per-channel deep FIFOs / radio cores.

Parameters:
- CHDR_W, 64, data width; only 64 is supported.
- USER_W, 16, width of e2v_tuser / v2e_tuser.
- NUM_CH, 2, number of radio channels (1..8).
- BASE_EPID, 16'h0002, EPID mapped to channel 0; channel k uses BASE_EPID+k.
- CNT_W, 32, width of the status counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- e2v_tdata/e2v_tuser/e2v_tlast/e2v_tvalid/e2v_tready  in,in,in,in,out  64/USER_W/1/1/1  ingress from Ethernet.
- ctrl_tdata/ctrl_tlast/ctrl_tvalid/ctrl_tready  out,out,out,in  64/1/1/1  control/management stream.
- tx_tdata  out  NUM_CH*64  TX data; channel k occupies bits [64k+63:64k].
- tx_tlast/tx_tvalid  out  NUM_CH each  per-channel TX sideband.
- tx_tready  in  NUM_CH  per-channel TX ready.
- resp_tdata/resp_tlast/resp_tvalid/resp_tready  in,in,in,out  64/1/1/1  radio response stream.
- rx_tdata  in  NUM_CH*64  per-channel RX data.
- rx_tlast/rx_tvalid  in  NUM_CH each  per-channel RX sideband.
- rx_tready  out  NUM_CH  per-channel RX ready.
- v2e_tdata/v2e_tuser/v2e_tlast/v2e_tvalid/v2e_tready  out,out,out,out,in  64/USER_W/1/1/1  egress to Ethernet.
- drop_cnt  out  CNT_W  count of dropped ingress packets, saturating.
- tx_pkt_cnt  out  NUM_CH*CNT_W  per-channel count of forwarded TX packets, wrapping.

Behaviour:
- Header fields (first beat of every packet): PktType=[55:53], Length=[31:16], DstEPID=[15:0].
- Ingress FSM, states IN_HDR, IN_PASS, IN_DROP.
  - IN_HDR decode is combinational on the header beat:
    - PktType 0, 1, 2 or 4 -> ctrl.
    - PktType 6 or 7 with DstEPID-BASE_EPID in [0,NUM_CH) -> tx[DstEPID-BASE_EPID].
    - Anything else (types 3 and 5, or EPID out of range) -> drop.
  - Destination is latched when the header beat is accepted.
- Routing is zero-latency pass-through with no internal buffering.
  - Selected output tvalid = e2v_tvalid; e2v_tready = selected output's tready.
  - All non-selected outputs hold tvalid=0.
  - In IN_DROP, e2v_tready=1.
- Transitions:
  - IN_HDR -> IN_PASS or IN_DROP when the header beat is accepted without tlast.
  - Header beat accepted with tlast: stay in IN_HDR. A single-beat drop still increments drop_cnt.
  - IN_PASS / IN_DROP -> IN_HDR when a tlast beat is accepted.
- Counters:
  - drop_cnt increments when a dropped packet's header is accepted; saturates at all-ones.
  - tx_pkt_cnt[k] increments when a tlast beat is accepted on channel k; wraps.
- Egress arbiter, states EG_IDLE, EG_GRANT.
  - Requesters: index 0 = resp, index 1+k = rx[k].
  - EG_IDLE: registered round-robin pick of the first valid requester after the last granted one. This costs one idle cycle.
  - EG_GRANT: pass-through with v2e_tvalid = grantee tvalid; only the grantee sees tready.
  - Return to EG_IDLE on grantee tlast & v2e_tready.
- v2e_tuser: header Length field on the first beat, held on all later beats of the same packet.
- Reset (rst_n=0 at a clock edge):
  - FSMs go to IN_HDR / EG_IDLE; round-robin pointer resets so the next search starts at index 0; counters clear.
  - All tvalid and all tready outputs are 0 during reset.
  - A packet in flight is abandoned; after reset the next beat is treated as a header.
- A tready deasserting mid-packet stalls only that path. Ingress and egress are fully independent.

Decomposition:
- Package eth_radio_pkg: localparams PKT_MGMT=0, PKT_STRS=1, PKT_STRC=2, PKT_CTRL=4, PKT_DATA=6, PKT_DATA_TS=7; header bit-field offsets; the route-select encoding.
- Sub-module chdr_pkt_rr_arbiter (params N, W, USER_W): contains the egress FSM, the round-robin pointer and the tuser length latch.

Test Plan:
- NUM_CH=2, BASE_EPID=2; send a ctrl packet (type 4, EPID 2, 3 beats) -> appears unchanged on ctrl with tlast on beat 3; tx_tvalid stays 2'b00.
- Send a data packet type 7 to EPID 3, 5 beats, with tx_tready[1] toggled every cycle -> all 5 beats arrive on tx[1]; tx_pkt_cnt[1]=1; e2v_tready mirrors tx_tready[1].
- Send a data packet to EPID 9 (4 beats), then a type-5 single-beat packet -> both consumed with e2v_tready=1; drop_cnt=2; no output tvalid asserted.
- resp, rx0 and rx1 all continuously valid with 2-beat packets -> v2e order is resp, rx0, rx1, resp, …, with one idle cycle between packets; v2e_tuser = each packet's Length field (e.g. 16).
- Assert rst_n=0 for 1 cycle in the middle of a tx[0] packet; after release send a ctrl packet -> the ctrl packet routes correctly and counters read 0.
- drop_cnt preloaded near saturation (CNT_W=4): 17 dropped packets -> drop_cnt holds 4'hF.

Source files
------------

// File: rtl/eth_radio_pkg.sv
// rtl/eth_radio_pkg.sv - CHDR packet types, header field offsets and route encodings
package eth_radio_pkg;

   localparam logic [2:0] PKT_MGMT    = 3'd0;
   localparam logic [2:0] PKT_STRS    = 3'd1;
   localparam logic [2:0] PKT_STRC    = 3'd2;
   localparam logic [2:0] PKT_CTRL    = 3'd4;
   localparam logic [2:0] PKT_DATA    = 3'd6;
   localparam logic [2:0] PKT_DATA_TS = 3'd7;

   localparam int HDR_TYPE_LSB = 53;
   localparam int HDR_TYPE_MSB = 55;
   localparam int HDR_LEN_LSB  = 16;
   localparam int HDR_LEN_MSB  = 31;
   localparam int HDR_EPID_LSB = 0;
   localparam int HDR_EPID_MSB = 15;

   typedef enum logic [1:0] {ROUTE_CTRL, ROUTE_TX, ROUTE_DROP} route_e;
   typedef enum logic [1:0] {IN_HDR, IN_PASS, IN_DROP} in_state_e;
   typedef enum logic {EG_IDLE, EG_GRANT} eg_state_e;

   // Type-only classification; data packets still need an EPID range check.
   function automatic route_e pkt_type_route(input logic [2:0] pkt_type);
      case (pkt_type)
         PKT_MGMT, PKT_STRS, PKT_STRC, PKT_CTRL: return ROUTE_CTRL;
         PKT_DATA, PKT_DATA_TS:                  return ROUTE_TX;
         default:                                return ROUTE_DROP;
      endcase
   endfunction

endpackage

// File: rtl/chdr_pkt_rr_arbiter.sv
// rtl/chdr_pkt_rr_arbiter.sv - packet-granular round-robin merge of N CHDR streams
module chdr_pkt_rr_arbiter
   import eth_radio_pkg::*;
#(
   parameter int N      = 3,
   parameter int W      = 64,
   parameter int USER_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N*W-1:0]    req_tdata,
   input  logic [N-1:0]      req_tlast,
   input  logic [N-1:0]      req_tvalid,
   output logic [N-1:0]      req_tready,
   output logic [W-1:0]      out_tdata,
   output logic [USER_W-1:0] out_tuser,
   output logic              out_tlast,
   output logic              out_tvalid,
   input  logic              out_tready
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   eg_state_e          state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               first_q, first_d;
   logic [USER_W-1:0]  len_q, len_d;

   logic               pick_vld;
   logic [PTR_W-1:0]   pick_idx;
   logic [USER_W-1:0]  hdr_len;
   logic               fire;

   // Search starts just after the last grantee so every requester gets a turn.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = 1; i <= N; i++) begin
         if (!pick_vld && req_tvalid[(int'(ptr_q) + i) % N]) begin
            pick_vld = 1'b1;
            pick_idx = PTR_W'((int'(ptr_q) + i) % N);
         end
      end
   end

   always_comb begin
      out_tdata  = req_tdata[ptr_q*W +: W];
      out_tlast  = req_tlast[ptr_q];
      hdr_len    = USER_W'(out_tdata[HDR_LEN_MSB:HDR_LEN_LSB]);
      out_tuser  = first_q ? hdr_len : len_q;
      out_tvalid = rst_n & (state_q == EG_GRANT) & req_tvalid[ptr_q];
      req_tready = '0;
      if (rst_n && state_q == EG_GRANT) begin
         req_tready[ptr_q] = out_tready;
      end
      fire = out_tvalid & out_tready;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      first_d = first_q;
      len_d   = len_q;
      case (state_q)
         EG_IDLE: begin
            if (pick_vld) begin
               state_d = EG_GRANT;
               ptr_d   = pick_idx;
               first_d = 1'b1;
            end
         end
         default: begin
            if (fire) begin
               if (first_q) begin
                  len_d = hdr_len;
               end
               first_d = 1'b0;
               if (out_tlast) begin
                  state_d = EG_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EG_IDLE;
         ptr_q   <= PTR_W'(N - 1);
         first_q <= 1'b1;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         first_q <= first_d;
         len_q   <= len_d;
      end
   end

endmodule

// File: rtl/eth_radio_stream_router.sv
// rtl/eth_radio_stream_router.sv - CHDR ingress router to ctrl/tx/drop plus egress RR merge
module eth_radio_stream_router
   import eth_radio_pkg::*;
#(
   parameter int          CHDR_W    = 64,
   parameter int          USER_W    = 16,
   parameter int          NUM_CH    = 2,
   parameter logic [15:0] BASE_EPID = 16'h0002,
   parameter int          CNT_W     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CHDR_W-1:0]        e2v_tdata,
   input  logic [USER_W-1:0]        e2v_tuser,
   input  logic                     e2v_tlast,
   input  logic                     e2v_tvalid,
   output logic                     e2v_tready,
   output logic [CHDR_W-1:0]        ctrl_tdata,
   output logic                     ctrl_tlast,
   output logic                     ctrl_tvalid,
   input  logic                     ctrl_tready,
   output logic [NUM_CH*CHDR_W-1:0] tx_tdata,
   output logic [NUM_CH-1:0]        tx_tlast,
   output logic [NUM_CH-1:0]        tx_tvalid,
   input  logic [NUM_CH-1:0]        tx_tready,
   input  logic [CHDR_W-1:0]        resp_tdata,
   input  logic                     resp_tlast,
   input  logic                     resp_tvalid,
   output logic                     resp_tready,
   input  logic [NUM_CH*CHDR_W-1:0] rx_tdata,
   input  logic [NUM_CH-1:0]        rx_tlast,
   input  logic [NUM_CH-1:0]        rx_tvalid,
   output logic [NUM_CH-1:0]        rx_tready,
   output logic [CHDR_W-1:0]        v2e_tdata,
   output logic [USER_W-1:0]        v2e_tuser,
   output logic                     v2e_tlast,
   output logic                     v2e_tvalid,
   input  logic                     v2e_tready,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [NUM_CH*CNT_W-1:0]  tx_pkt_cnt
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   in_state_e                in_state_q, in_state_d;
   route_e                   route_q, route_d;
   logic [CH_W-1:0]          ch_q, ch_d;
   logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
   logic [NUM_CH*CNT_W-1:0]  tx_pkt_cnt_q, tx_pkt_cnt_d;

   route_e                   hdr_route, cur_route;
   logic [15:0]              hdr_epid_ofs;
   logic [CH_W-1:0]          hdr_ch, cur_ch;
   logic                     sel_ready;
   logic                     e2v_fire;
   logic                     unused_e2v_tuser;

   assign unused_e2v_tuser = ^e2v_tuser;

   always_comb begin
      hdr_epid_ofs = e2v_tdata[HDR_EPID_MSB:HDR_EPID_LSB] - BASE_EPID;
      hdr_ch       = hdr_epid_ofs[CH_W-1:0];
      hdr_route    = pkt_type_route(e2v_tdata[HDR_TYPE_MSB:HDR_TYPE_LSB]);
      // Unsigned wrap makes EPIDs below BASE_EPID land out of range too.
      if (hdr_route == ROUTE_TX && hdr_epid_ofs >= 16'(NUM_CH)) begin
         hdr_route = ROUTE_DROP;
      end
      cur_route = (in_state_q == IN_HDR) ? hdr_route : route_q;
      cur_ch    = (in_state_q == IN_HDR) ? hdr_ch : ch_q;
   end

   always_comb begin
      case (cur_route)
         ROUTE_CTRL: sel_ready = ctrl_tready;
         ROUTE_TX:   sel_ready = tx_tready[cur_ch];
         default:    sel_ready = 1'b1;
      endcase
      e2v_tready  = rst_n & sel_ready;
      e2v_fire    = e2v_tvalid & e2v_tready;
      ctrl_tdata  = e2v_tdata;
      ctrl_tlast  = e2v_tlast;
      ctrl_tvalid = rst_n & e2v_tvalid & (cur_route == ROUTE_CTRL);
      tx_tdata    = {NUM_CH{e2v_tdata}};
      tx_tlast    = {NUM_CH{e2v_tlast}};
      tx_tvalid   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         tx_tvalid[k] = rst_n & e2v_tvalid & (cur_route == ROUTE_TX) & (cur_ch == CH_W'(k));
      end
   end

   always_comb begin
      in_state_d   = in_state_q;
      route_d      = route_q;
      ch_d         = ch_q;
      drop_cnt_d   = drop_cnt_q;
      tx_pkt_cnt_d = tx_pkt_cnt_q;
      if (e2v_fire) begin
         if (in_state_q == IN_HDR) begin
            route_d = hdr_route;
            ch_d    = hdr_ch;
            if (hdr_route == ROUTE_DROP && drop_cnt_q != '1) begin
               drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
            if (!e2v_tlast) begin
               in_state_d = (hdr_route == ROUTE_DROP) ? IN_DROP : IN_PASS;
            end
         end else if (e2v_tlast) begin
            in_state_d = IN_HDR;
         end
         for (int k = 0; k < NUM_CH; k++) begin
            if (e2v_tlast && cur_route == ROUTE_TX && cur_ch == CH_W'(k)) begin
               tx_pkt_cnt_d[k*CNT_W +: CNT_W] = tx_pkt_cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_state_q   <= IN_HDR;
         route_q      <= ROUTE_DROP;
         ch_q         <= '0;
         drop_cnt_q   <= '0;
         tx_pkt_cnt_q <= '0;
      end else begin
         in_state_q   <= in_state_d;
         route_q      <= route_d;
         ch_q         <= ch_d;
         drop_cnt_q   <= drop_cnt_d;
         tx_pkt_cnt_q <= tx_pkt_cnt_d;
      end
   end

   assign drop_cnt   = drop_cnt_q;
   assign tx_pkt_cnt = tx_pkt_cnt_q;

   // Requester 0 is the radio response stream, 1+k is rx[k].
   logic [(NUM_CH+1)*CHDR_W-1:0] arb_tdata;
   logic [NUM_CH:0]              arb_tlast;
   logic [NUM_CH:0]              arb_tvalid;
   logic [NUM_CH:0]              arb_tready;

   assign arb_tdata   = {rx_tdata, resp_tdata};
   assign arb_tlast   = {rx_tlast, resp_tlast};
   assign arb_tvalid  = {rx_tvalid, resp_tvalid};
   assign resp_tready = arb_tready[0];
   assign rx_tready   = arb_tready[NUM_CH:1];

   chdr_pkt_rr_arbiter #(
      .N      (NUM_CH + 1),
      .W      (CHDR_W),
      .USER_W (USER_W)
   ) u_egress_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_tdata  (arb_tdata),
      .req_tlast  (arb_tlast),
      .req_tvalid (arb_tvalid),
      .req_tready (arb_tready),
      .out_tdata  (v2e_tdata),
      .out_tuser  (v2e_tuser),
      .out_tlast  (v2e_tlast),
      .out_tvalid (v2e_tvalid),
      .out_tready (v2e_tready)
   );

endmodule

// File: tb/tb_eth_radio_stream_router.sv
// tb/tb_eth_radio_stream_router.sv - randomized self-checking bench for eth_radio_stream_router
module tb_eth_radio_stream_router;

   localparam int NUM_CH  = 2;
   localparam int CNT_W   = 4;
   localparam int USER_W  = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [63:0]             e2v_tdata;
   logic [USER_W-1:0]       e2v_tuser;
   logic                    e2v_tlast, e2v_tvalid, e2v_tready;
   logic [63:0]             ctrl_tdata;
   logic                    ctrl_tlast, ctrl_tvalid, ctrl_tready;
   logic [NUM_CH*64-1:0]    tx_tdata;
   logic [NUM_CH-1:0]       tx_tlast, tx_tvalid, tx_tready;
   logic [63:0]             resp_tdata;
   logic                    resp_tlast, resp_tvalid, resp_tready;
   logic [NUM_CH*64-1:0]    rx_tdata;
   logic [NUM_CH-1:0]       rx_tlast, rx_tvalid, rx_tready;
   logic [63:0]             v2e_tdata;
   logic [USER_W-1:0]       v2e_tuser;
   logic                    v2e_tlast, v2e_tvalid, v2e_tready;
   logic [CNT_W-1:0]        drop_cnt;
   logic [NUM_CH*CNT_W-1:0] tx_pkt_cnt;

   always #5 clk = ~clk;

   eth_radio_stream_router #(
      .CHDR_W    (64),
      .USER_W    (USER_W),
      .NUM_CH    (NUM_CH),
      .BASE_EPID (16'h0002),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .e2v_tdata   (e2v_tdata),
      .e2v_tuser   (e2v_tuser),
      .e2v_tlast   (e2v_tlast),
      .e2v_tvalid  (e2v_tvalid),
      .e2v_tready  (e2v_tready),
      .ctrl_tdata  (ctrl_tdata),
      .ctrl_tlast  (ctrl_tlast),
      .ctrl_tvalid (ctrl_tvalid),
      .ctrl_tready (ctrl_tready),
      .tx_tdata    (tx_tdata),
      .tx_tlast    (tx_tlast),
      .tx_tvalid   (tx_tvalid),
      .tx_tready   (tx_tready),
      .resp_tdata  (resp_tdata),
      .resp_tlast  (resp_tlast),
      .resp_tvalid (resp_tvalid),
      .resp_tready (resp_tready),
      .rx_tdata    (rx_tdata),
      .rx_tlast    (rx_tlast),
      .rx_tvalid   (rx_tvalid),
      .rx_tready   (rx_tready),
      .v2e_tdata   (v2e_tdata),
      .v2e_tuser   (v2e_tuser),
      .v2e_tlast   (v2e_tlast),
      .v2e_tvalid  (v2e_tvalid),
      .v2e_tready  (v2e_tready),
      .drop_cnt    (drop_cnt),
      .tx_pkt_cnt  (tx_pkt_cnt)
   );

   int checks = 0;
   int errors = 0;
   int drop_exp;
   int tx_exp [NUM_CH];
   int eg_last;
   logic [64:0] bmem [3][64];
   int hd [3];
   int tl [3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0 = ctrl, 1 = tx[ch], 2 = drop
   function automatic int route_of(input int t, input int epid, output int ch);
      ch = epid - 2;
      if (t == 0 || t == 1 || t == 2 || t == 4) return 0;
      if ((t == 6 || t == 7) && epid >= 2 && epid < 2 + NUM_CH) return 1;
      return 2;
   endfunction

   task automatic check_counters();
      chk("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
      for (int k = 0; k < NUM_CH; k++) begin
         chk("tx_pkt_cnt", 64'(tx_pkt_cnt[k*CNT_W +: CNT_W]), 64'(tx_exp[k]));
      end
   endtask

   task automatic send_pkt(input int ptype, input int epid, input int nb, input int nsend, input bit toggle);
      logic [63:0] bt [16];
      int route, ch, i, budget;
      logic exp_rdy;
      for (int b = 0; b < nb; b++) bt[b] = {$urandom, $urandom};
      bt[0][55:53] = 3'(ptype);
      bt[0][15:0]  = 16'(epid);
      route = route_of(ptype, epid, ch);
      i = 0;
      budget = 0;
      while (i < nsend && budget < 200) begin
         @(posedge clk); #1;
         e2v_tvalid  = ($urandom_range(0, 4) != 0);
         e2v_tdata   = bt[i];
         e2v_tlast   = (i == nb - 1);
         e2v_tuser   = 16'($urandom);
         ctrl_tready = 1'($urandom_range(0, 1));
         tx_tready   = toggle ? ~tx_tready : 2'($urandom_range(0, 3));
         #1;
         exp_rdy = (route == 0) ? ctrl_tready : (route == 1) ? tx_tready[ch] : 1'b1;
         chk("ctrl_tvalid", 64'(ctrl_tvalid), 64'(e2v_tvalid && route == 0));
         chk("tx_tvalid", 64'(tx_tvalid), (e2v_tvalid && route == 1) ? 64'(1 << ch) : 64'd0);
         chk("e2v_tready", 64'(e2v_tready), 64'(exp_rdy));
         chk("v2e_tvalid_quiet", 64'(v2e_tvalid), 64'd0);
         if (e2v_tvalid && exp_rdy) begin
            if (route == 0) begin
               chk("ctrl_tdata", ctrl_tdata, bt[i]);
               chk("ctrl_tlast", 64'(ctrl_tlast), 64'(i == nb - 1));
            end else if (route == 1) begin
               chk("tx_tdata", tx_tdata[ch*64 +: 64], bt[i]);
               chk("tx_tlast", 64'(tx_tlast[ch]), 64'(i == nb - 1));
            end
            if (i == 0 && route == 2 && drop_exp != CNT_MAX) drop_exp++;
            if (i == nb - 1 && route == 1) tx_exp[ch] = (tx_exp[ch] + 1) & CNT_MAX;
            i++;
         end
         budget++;
      end
      if (budget >= 200) chk("ingress_budget", 64'd0, 64'd1);
      @(posedge clk); #1;
      e2v_tvalid = 1'b0;
      check_counters();
   endtask

   task automatic run_egress();
      int src, budget, nb;
      bit granted, first;
      logic [15:0] cur_len, len;
      logic [63:0] d;
      logic [64:0] head;
      logic [NUM_CH-1:0] exp_rx;
      for (int r = 0; r < 3; r++) begin
         hd[r] = 0;
         tl[r] = 0;
         for (int p = 0; p < 4; p++) begin
            nb  = (p == 0) ? 2 : $urandom_range(1, 4);
            len = (p == 0) ? 16'd16 : 16'($urandom);
            for (int b = 0; b < nb; b++) begin
               d = {$urandom, $urandom};
               if (b == 0) d[31:16] = len;
               bmem[r][tl[r]] = {(b == nb - 1), d};
               tl[r]++;
            end
         end
      end
      granted = 0; first = 0; src = 0; cur_len = '0; budget = 0;
      while ((hd[0] < tl[0] || hd[1] < tl[1] || hd[2] < tl[2] || granted) && budget < 600) begin
         @(posedge clk); #1;
         resp_tvalid = (hd[0] < tl[0]);
         resp_tdata  = bmem[0][hd[0]][63:0];
         resp_tlast  = bmem[0][hd[0]][64];
         for (int k = 0; k < NUM_CH; k++) begin
            rx_tvalid[k]          = (hd[k+1] < tl[k+1]);
            rx_tdata[k*64 +: 64]  = bmem[k+1][hd[k+1]][63:0];
            rx_tlast[k]           = bmem[k+1][hd[k+1]][64];
         end
         v2e_tready = ($urandom_range(0, 3) != 0);
         #1;
         if (!granted) begin
            chk("v2e_tvalid_idle", 64'(v2e_tvalid), 64'd0);
            chk("resp_tready_idle", 64'(resp_tready), 64'd0);
            chk("rx_tready_idle", 64'(rx_tready), 64'd0);
            for (int i = 1; i <= 3; i++) begin
               if (!granted && hd[(eg_last + i) % 3] < tl[(eg_last + i) % 3]) begin
                  src = (eg_last + i) % 3;
                  granted = 1;
                  first = 1;
               end
            end
            if (granted) eg_last = src;
         end else begin
            head = bmem[src][hd[src]];
            exp_rx = '0;
            if (src > 0 && v2e_tready) exp_rx[src-1] = 1'b1;
            chk("v2e_tvalid", 64'(v2e_tvalid), 64'd1);
            chk("v2e_tdata", v2e_tdata, head[63:0]);
            chk("v2e_tlast", 64'(v2e_tlast), 64'(head[64]));
            chk("v2e_tuser", 64'(v2e_tuser), first ? 64'(head[31:16]) : 64'(cur_len));
            chk("resp_tready", 64'(resp_tready), 64'(src == 0 && v2e_tready));
            chk("rx_tready", 64'(rx_tready), 64'(exp_rx));
            if (v2e_tready) begin
               if (first) cur_len = head[31:16];
               first = 0;
               hd[src]++;
               if (head[64]) granted = 0;
            end
         end
         budget++;
      end
      if (budget >= 600) chk("egress_budget", 64'd0, 64'd1);
      @(posedge clk); #1;
      resp_tvalid = 1'b0;
      rx_tvalid   = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      e2v_tdata = '0; e2v_tuser = '0; e2v_tlast = 1'b0; e2v_tvalid = 1'b1;
      ctrl_tready = 1'b1; tx_tready = '1;
      resp_tdata = '0; resp_tlast = 1'b1; resp_tvalid = 1'b1;
      rx_tdata = '0; rx_tlast = '1; rx_tvalid = '1;
      v2e_tready = 1'b1;
      drop_exp = 0; eg_last = 2;
      for (int k = 0; k < NUM_CH; k++) tx_exp[k] = 0;

      @(posedge clk); @(posedge clk); #1;
      chk("rst_e2v_tready", 64'(e2v_tready), 64'd0);
      chk("rst_ctrl_tvalid", 64'(ctrl_tvalid), 64'd0);
      chk("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
      chk("rst_v2e_tvalid", 64'(v2e_tvalid), 64'd0);
      chk("rst_resp_tready", 64'(resp_tready), 64'd0);
      chk("rst_rx_tready", 64'(rx_tready), 64'd0);
      check_counters();
      rst_n = 1'b1;
      e2v_tvalid = 1'b0; resp_tvalid = 1'b0; rx_tvalid = '0;

      send_pkt(4, 2, 3, 3, 0);
      send_pkt(7, 3, 5, 5, 1);
      send_pkt(6, 9, 4, 4, 0);
      send_pkt(5, 2, 1, 1, 0);
      chk("drop_after_two", 64'(drop_cnt), 64'd2);

      run_egress();

      for (int n = 0; n < 24; n++) begin
         send_pkt($urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(1, 5),
                  0, 0);
      end
      for (int n = 0; n < 24; n++) begin
         int nb;
         nb = $urandom_range(1, 5);
         send_pkt($urandom_range(0, 7), $urandom_range(0, 5), nb, nb, 0);
      end

      send_pkt(6, 2, 4, 2, 0);
      rst_n = 1'b0;
      e2v_tvalid = 1'b1; e2v_tdata = {$urandom, $urandom};
      tx_tready = '1; ctrl_tready = 1'b1;
      #1;
      chk("midrst_tx_tvalid", 64'(tx_tvalid), 64'd0);
      chk("midrst_ctrl_tvalid", 64'(ctrl_tvalid), 64'd0);
      chk("midrst_e2v_tready", 64'(e2v_tready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      e2v_tvalid = 1'b0;
      drop_exp = 0; eg_last = 2;
      for (int k = 0; k < NUM_CH; k++) tx_exp[k] = 0;
      check_counters();
      send_pkt(0, 77, 2, 2, 0);

      for (int n = 0; n < 17; n++) send_pkt(3, 2, 1, 1, 0);
      chk("drop_saturated", 64'(drop_cnt), 64'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
